// File: rtl/result_checker.sv
// result_checker: queued field checks against register-file or data-memory
// reads. Each check waits for a trigger value on the flag register, reads one
// word, extracts and extends a bit field, and compares it with an expected
// value. Pass/fail counts saturate; a flag wait that never resolves halts the
// checker until reset.
module result_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 14,
  parameter int DEPTH          = 16,
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          chk_valid,
  output logic                          chk_ready,
  input  logic                          chk_space,
  input  logic [ADDR_WIDTH-1:0]         chk_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] chk_shift,
  input  logic [$clog2(DATA_WIDTH):0]   chk_width,
  input  logic                          chk_signed,
  input  logic [DATA_WIDTH-1:0]         chk_trigger,
  input  logic [DATA_WIDTH-1:0]         chk_expect,
  input  logic [DATA_WIDTH-1:0]         flag_value,
  output logic                          rd_req,
  output logic                          rd_space,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  output logic [15:0]                   pass_cnt,
  output logic [15:0]                   fail_cnt,
  output logic                          fail_pulse,
  output logic [15:0]                   fail_index,
  output logic [DATA_WIDTH-1:0]         fail_got,
  output logic                          done,
  output logic                          timeout
);

  localparam int SW = $clog2(DATA_WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(RD_LATENCY + 1);

  localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(RD_LATENCY - 1);

  typedef struct packed {
    logic                  space;
    logic [ADDR_WIDTH-1:0] addr;
    logic [SW-1:0]         shift;
    logic [SW:0]           width;
    logic                  sgn;
    logic [DATA_WIDTH-1:0] trigger;
    logic [DATA_WIDTH-1:0] expect_val;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE, WAIT_FLAG, READ, WAIT_DATA, COMPARE, HALT
  } state_t;

  state_t                state;
  entry_t                queue_mem [DEPTH];
  entry_t                in_entry;
  entry_t                work;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic                  push;
  logic                  pop;
  logic [WW-1:0]         wait_cnt;
  logic [LW-1:0]         lat_cnt;
  logic [DATA_WIDTH-1:0] field;
  logic [15:0]           check_idx;
  logic                  any_done;

  logic [DATA_WIDTH-1:0] ext_shifted;
  logic [DATA_WIDTH-1:0] ext_mask;
  logic [DATA_WIDTH-1:0] ext_raw;
  logic [DATA_WIDTH-1:0] ext_field;
  logic                  ext_sign;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_entry = '{space:      chk_space,
                      addr:       chk_addr,
                      shift:      chk_shift,
                      width:      chk_width,
                      sgn:        chk_signed,
                      trigger:    chk_trigger,
                      expect_val: chk_expect};

  // Ready never looks ahead to a same-cycle pop; HALT blocks new entries.
  assign chk_ready = (count != DEPTH_CNT) && (state != HALT);
  assign push      = chk_valid && chk_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign done      = (state == IDLE) && (count == '0) && any_done;

  // Queue storage: written on every accepted entry.
  // NOTE: the storage array has no reset; clearing the pointers and count
  // makes every stale slot unreachable, and leaving it unreset keeps it a
  // plain memory.
  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= in_entry;
  end

  // Queue pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Field extraction from the returning read word: bits shifted in from
  // above DATA_WIDTH are zero, then the field is masked and optionally
  // sign-extended from its top bit.
  // NOTE: every signal here is assigned on every pass, so no latch is inferred.
  always_comb begin
    ext_shifted = rd_data >> work.shift;
    ext_mask    = ~({DATA_WIDTH{1'b1}} << work.width);
    ext_raw     = ext_shifted & ext_mask;
    ext_sign    = |(ext_raw & ext_mask & ~(ext_mask >> 1));
    ext_field   = (work.sgn && ext_sign) ? (ext_raw | ~ext_mask) : ext_raw;
  end

  // Check sequencer with registered outputs. Reset returns to IDLE with no
  // read outstanding, so data from a read issued before reset is never
  // sampled: rd_data is only looked at in WAIT_DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      work       <= '0;
      wait_cnt   <= '0;
      lat_cnt    <= '0;
      field      <= '0;
      rd_req     <= 1'b0;
      rd_space   <= 1'b0;
      rd_addr    <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_pulse <= 1'b0;
      fail_index <= '0;
      fail_got   <= '0;
      timeout    <= 1'b0;
      check_idx  <= '0;
      any_done   <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      rd_req     <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            work     <= queue_mem[rd_ptr];
            wait_cnt <= '0;
            state    <= WAIT_FLAG;
          end
        end
        WAIT_FLAG: begin
          if (flag_value == work.trigger) begin
            rd_req   <= 1'b1;
            rd_space <= work.space;
            rd_addr  <= work.addr;
            state    <= READ;
          end else if (wait_cnt == WAIT_LAST) begin
            // This non-matching cycle brings the wait count to the limit.
            state      <= HALT;
            timeout    <= 1'b1;
            fail_cnt   <= sat_inc(fail_cnt);
            fail_pulse <= 1'b1;
            fail_index <= check_idx;
            fail_got   <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        READ: begin
          lat_cnt <= '0;
          state   <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (lat_cnt == LAT_LAST) begin
            field <= ext_field;
            state <= COMPARE;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        COMPARE: begin
          if (field == work.expect_val) begin
            pass_cnt <= sat_inc(pass_cnt);
          end else begin
            fail_cnt   <= sat_inc(fail_cnt);
            fail_pulse <= 1'b1;
            fail_index <= check_idx;
            fail_got   <= field;
          end
          check_idx <= check_idx + 16'd1;
          any_done  <= 1'b1;
          state     <= IDLE;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
